// File: rtl/cnn_param_stream_loader.sv
// Streams DATA_W-bit CNN parameter words into a byte-wide parameter RAM,
// one byte per cycle, with byte order select, checksum and overflow abort.
module cnn_param_stream_loader #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  num_words,
    input  logic              little_endian,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [ADDR_W-1:0] ram_address,
    output logic [7:0]        ram_data,
    output logic              ram_write,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [7:0]        checksum
);

    localparam int BPW   = DATA_W / 8;
    localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCEPT = 2'd1;
    localparam logic [1:0] EMIT   = 2'd2;
    localparam logic [1:0] FINISH = 2'd3;

    logic [1:0]        state;
    logic [DATA_W-1:0] wordReg;
    logic [IDX_W-1:0]  byteIdx;
    logic [CNT_W-1:0]  wordCnt;
    logic [CNT_W-1:0]  numWordsReg;
    logic [ADDR_W-1:0] nextAddr;
    logic [ADDR_W-1:0] ramAddrReg;
    logic [7:0]        ramDataReg;
    logic [7:0]        sumReg;
    logic              leReg;
    logic              ovfReg;
    logic              lastByte;
    logic              lastWord;
    logic              addrTop;

    // Byte idx of a word in transfer order (idx 0 goes out first).
    function automatic logic [7:0] pickByte(
        input logic [DATA_W-1:0] w,
        input int                idx,
        input logic              le
    );
        int sh;
        sh = le ? 8 * idx : 8 * (BPW - 1 - idx);
        return 8'(w >> sh);
    endfunction

    // End-of-word, end-of-load and top-of-RAM conditions for the byte being written.
    always_comb begin
        lastByte = (byteIdx == IDX_W'(BPW - 1));
        lastWord = ((wordCnt + CNT_W'(1)) == numWordsReg);
        addrTop  = &ramAddrReg;
    end

    // Load sequencer: latch parameters, take words, emit bytes, finish.
    always_ff @(posedge clk) begin
        if (RST) begin
            state       <= IDLE;
            wordReg     <= '0;
            byteIdx     <= '0;
            wordCnt     <= '0;
            numWordsReg <= '0;
            nextAddr    <= '0;
            ramAddrReg  <= '0;
            ramDataReg  <= '0;
            sumReg      <= '0;
            leReg       <= 1'b0;
            ovfReg      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        numWordsReg <= num_words;
                        leReg       <= little_endian;
                        nextAddr    <= base_addr;
                        wordCnt     <= '0;
                        sumReg      <= '0;
                        ovfReg      <= 1'b0;
                        state       <= (num_words == '0) ? FINISH : ACCEPT;
                    end
                end
                ACCEPT: begin
                    if (in_valid) begin
                        wordReg    <= in_data;
                        byteIdx    <= '0;
                        ramDataReg <= pickByte(in_data, 0, leReg);
                        ramAddrReg <= nextAddr;
                        state      <= EMIT;
                    end
                end
                EMIT: begin
                    sumReg <= sumReg + ramDataReg;
                    if (addrTop && !(lastByte && lastWord)) begin
                        // Refuse to wrap to address 0; abort the load.
                        ovfReg <= 1'b1;
                        state  <= FINISH;
                    end else if (lastByte) begin
                        wordCnt  <= wordCnt + CNT_W'(1);
                        nextAddr <= ramAddrReg + ADDR_W'(1);
                        state    <= lastWord ? FINISH : ACCEPT;
                    end else begin
                        byteIdx    <= byteIdx + IDX_W'(1);
                        ramAddrReg <= ramAddrReg + ADDR_W'(1);
                        ramDataReg <= pickByte(wordReg, int'(byteIdx) + 1, leReg);
                    end
                end
                FINISH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Status strobes decode directly from the state register.
    always_comb begin
        in_ready    = (state == ACCEPT);
        ram_write   = (state == EMIT);
        busy        = (state != IDLE);
        done        = (state == FINISH);
        ram_address = ramAddrReg;
        ram_data    = ramDataReg;
        overflow    = ovfReg;
        checksum    = sumReg;
    end

endmodule

// File: tb/tb_cnn_param_stream_loader.sv
// Scoreboard bench for cnn_param_stream_loader: 16-bit and 32-bit instances,
// expected RAM writes queued at stimulus time and popped on each write.
module tb_cnn_param_stream_loader;

    logic        clk = 1'b0;
    logic        RST = 1'b1;

    logic        start16 = 1'b0;
    logic [15:0] base16 = '0;
    logic [15:0] num16 = '0;
    logic        le16 = 1'b0;
    logic        valid16 = 1'b0;
    logic [15:0] data16 = '0;
    logic        ready16;
    logic [15:0] addr16;
    logic [7:0]  rdata16;
    logic        wr16;
    logic        busy16;
    logic        done16;
    logic        ovf16;
    logic [7:0]  sum16;

    logic        start32 = 1'b0;
    logic [15:0] base32 = '0;
    logic [15:0] num32 = '0;
    logic        le32 = 1'b0;
    logic        valid32 = 1'b0;
    logic [31:0] data32 = '0;
    logic        ready32;
    logic [15:0] addr32;
    logic [7:0]  rdata32;
    logic        wr32;
    logic        busy32;
    logic        done32;
    logic        ovf32;
    logic [7:0]  sum32;

    logic [23:0] q16[$];
    logic [23:0] q32[$];
    logic [23:0] e16;
    logic [23:0] e32;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cnn_param_stream_loader #(.DATA_W(16), .ADDR_W(16), .CNT_W(16)) dut16 (
        .clk(clk), .RST(RST), .start(start16), .base_addr(base16),
        .num_words(num16), .little_endian(le16), .in_valid(valid16),
        .in_data(data16), .in_ready(ready16), .ram_address(addr16),
        .ram_data(rdata16), .ram_write(wr16), .busy(busy16),
        .done(done16), .overflow(ovf16), .checksum(sum16)
    );

    cnn_param_stream_loader #(.DATA_W(32), .ADDR_W(16), .CNT_W(16)) dut32 (
        .clk(clk), .RST(RST), .start(start32), .base_addr(base32),
        .num_words(num32), .little_endian(le32), .in_valid(valid32),
        .in_data(data32), .in_ready(ready32), .ram_address(addr32),
        .ram_data(rdata32), .ram_write(wr32), .busy(busy32),
        .done(done32), .overflow(ovf32), .checksum(sum32)
    );

    task automatic checkEq(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Every RAM write must match the head of the expected queue.
    always @(negedge clk) begin
        if (wr16 === 1'b1) begin
            if (q16.size() == 0) begin
                checkEq("spurious16", 32'(wr16), 0);
            end else begin
                e16 = q16.pop_front();
                checkEq("addr16", 32'(addr16), 32'(e16[23:8]));
                checkEq("data16", 32'(rdata16), 32'(e16[7:0]));
            end
        end
    end

    // Same for the 32-bit instance.
    always @(negedge clk) begin
        if (wr32 === 1'b1) begin
            if (q32.size() == 0) begin
                checkEq("spurious32", 32'(wr32), 0);
            end else begin
                e32 = q32.pop_front();
                checkEq("addr32", 32'(addr32), 32'(e32[23:8]));
                checkEq("data32", 32'(rdata32), 32'(e32[7:0]));
            end
        end
    end

    task automatic pushWord(input logic [15:0] w, input logic le,
                            inout logic [15:0] a, inout logic [7:0] s);
        logic [7:0] b0;
        logic [7:0] b1;
        b0 = le ? w[7:0] : w[15:8];
        b1 = le ? w[15:8] : w[7:0];
        q16.push_back({a, b0});
        q16.push_back({a + 16'd1, b1});
        a = a + 16'd2;
        s = s + b0 + b1;
    endtask

    task automatic startLoad(input logic [15:0] b, input logic [15:0] n,
                             input logic le);
        @(negedge clk);
        start16 = 1'b1;
        base16  = b;
        num16   = n;
        le16    = le;
        @(negedge clk);
        start16 = 1'b0;
    endtask

    task automatic feedWord(input logic [15:0] w);
        int t;
        t = 0;
        valid16 = 1'b1;
        data16  = w;
        while (ready16 !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        checkEq("ready16", 32'(ready16), 1);
        @(negedge clk);
        valid16 = 1'b0;
    endtask

    task automatic finishLoad(input int expDelay, input logic [7:0] expSum,
                              input logic expOvf);
        int t;
        t = 0;
        while (done16 !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        checkEq("done16", 32'(done16), 1);
        checkEq("doneDelay16", 32'(t), 32'(expDelay));
        checkEq("sum16", 32'(sum16), 32'(expSum));
        checkEq("ovf16", 32'(ovf16), 32'(expOvf));
        checkEq("qEmpty16", 32'(q16.size()), 0);
        @(negedge clk);
        checkEq("doneLow16", 32'(done16), 0);
        checkEq("idle16", 32'(busy16), 0);
    endtask

    task automatic checkReset16();
        checkEq("rstReady", 32'(ready16), 0);
        checkEq("rstWrite", 32'(wr16), 0);
        checkEq("rstBusy", 32'(busy16), 0);
        checkEq("rstDone", 32'(done16), 0);
        checkEq("rstOvf", 32'(ovf16), 0);
        checkEq("rstAddr", 32'(addr16), 0);
        checkEq("rstData", 32'(rdata16), 0);
        checkEq("rstSum", 32'(sum16), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] a;
        logic [7:0]  s;
        logic [31:0] w32;
        int          t;

        repeat (3) @(negedge clk);
        checkReset16();
        RST = 1'b0;

        // MSB-first, three words
        a = 16'h0010;
        s = 8'h00;
        pushWord(16'h1234, 1'b0, a, s);
        pushWord(16'h5678, 1'b0, a, s);
        pushWord(16'h9ABC, 1'b0, a, s);
        startLoad(16'h0010, 16'd3, 1'b0);
        feedWord(16'h1234);
        feedWord(16'h5678);
        feedWord(16'h9ABC);
        finishLoad(2, s, 1'b0);
        checkEq("addrHold16", 32'(addr16), 32'h15);

        // LSB-first, same words
        a = 16'h0010;
        s = 8'h00;
        pushWord(16'h1234, 1'b1, a, s);
        pushWord(16'h5678, 1'b1, a, s);
        pushWord(16'h9ABC, 1'b1, a, s);
        startLoad(16'h0010, 16'd3, 1'b1);
        feedWord(16'h1234);
        feedWord(16'h5678);
        feedWord(16'h9ABC);
        finishLoad(2, s, 1'b0);

        // Empty load: no writes, checksum cleared
        startLoad(16'h0080, 16'd0, 1'b0);
        finishLoad(0, 8'h00, 1'b0);

        // Address overflow: one byte at the top, then abort
        q16.push_back({16'hFFFF, 8'hA5});
        startLoad(16'hFFFF, 16'd1, 1'b0);
        feedWord(16'hA55A);
        finishLoad(1, 8'hA5, 1'b1);

        // Reset in the middle of word 2 of 3
        q16.push_back({16'h0100, 8'h11});
        q16.push_back({16'h0101, 8'h11});
        q16.push_back({16'h0102, 8'h22});
        startLoad(16'h0100, 16'd3, 1'b0);
        feedWord(16'h1111);
        feedWord(16'h2222);
        RST = 1'b1;
        @(negedge clk);
        checkReset16();
        checkEq("rstQueue", 32'(q16.size()), 0);
        RST = 1'b0;

        // Fresh load after reset
        a = 16'h0200;
        s = 8'h00;
        pushWord(16'h0102, 1'b1, a, s);
        pushWord(16'h0304, 1'b1, a, s);
        startLoad(16'h0200, 16'd2, 1'b1);
        feedWord(16'h0102);
        feedWord(16'h0304);
        finishLoad(2, s, 1'b0);

        // 32-bit word, valid held from the cycle after start
        w32 = 32'hDEADBEEF;
        s   = 8'h00;
        for (int i = 0; i < 4; i++) begin
            q32.push_back({16'h0040 + 16'(i), w32[31 - 8 * i -: 8]});
            s = s + w32[31 - 8 * i -: 8];
        end
        @(negedge clk);
        start32 = 1'b1;
        base32  = 16'h0040;
        num32   = 16'd1;
        le32    = 1'b0;
        @(negedge clk);
        start32 = 1'b0;
        valid32 = 1'b1;
        data32  = w32;
        t = 0;
        while (ready32 !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        checkEq("ready32", 32'(ready32), 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            valid32 = 1'b0;
            checkEq("rdyLow32", 32'(ready32), 0);
            checkEq("wr32", 32'(wr32), 1);
        end
        @(negedge clk);
        checkEq("done32", 32'(done32), 1);
        checkEq("sum32", 32'(sum32), 32'(s));
        checkEq("ovf32", 32'(ovf32), 0);
        checkEq("qEmpty32", 32'(q32.size()), 0);
        @(negedge clk);
        checkEq("idle32", 32'(busy32), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
